// File: rtl/crc_pkg.sv
// ---------------------------------------------------------------------------
// crc_pkg
// Shared definitions for the streaming CRC checker:
//   - CRC-32 (IEEE 802.3) constants: polynomial, init, final XOR and the
//     good-frame residue seen when the CRC is folded in along with the data.
//   - keep_to_nbytes: turns a last-beat byte-keep mask into a contiguous byte
//     count plus a flag for a hole in the mask.
//   - reflect32: bit-reverses a 32-bit word.
//   - FSM state encoding for the message tracker.
// ---------------------------------------------------------------------------
package crc_pkg;

   localparam logic [31:0] CRC32_POLY    = 32'h04C11DB7;
   localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
   localparam logic [31:0] CRC32_XOROUT  = 32'hFFFFFFFF;
   localparam logic [31:0] CRC32_RESIDUE = 32'hC704DD7B;

   // Widest keep mask supported (DATA_WIDTH = 512).
   localparam int unsigned MAX_KEEP_BITS = 64;

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_ACCUM = 1'b1
   } fsm_state_e;

   typedef struct packed {
      logic [6:0] nbytes;  // contiguous ones starting at bit 0
      logic       err;     // a set bit follows the first clear bit
   } keep_info_t;

   // Only the lowest 'width' bits of the mask are meaningful.
   function automatic keep_info_t keep_to_nbytes(input logic [MAX_KEEP_BITS-1:0] keep,
                                                 input int                       width);
      keep_info_t r;
      logic       gap;
      r   = '0;
      gap = 1'b0;
      for (int i = 0; i < MAX_KEEP_BITS; i++) begin
         if (i < width) begin
            if (keep[i]) begin
               if (gap) r.err    = 1'b1;
               else     r.nbytes = r.nbytes + 7'd1;
            end else begin
               gap = 1'b1;
            end
         end
      end
      return r;
   endfunction

   function automatic logic [31:0] reflect32(input logic [31:0] v);
      logic [31:0] r;
      for (int i = 0; i < 32; i++) r[i] = v[31-i];
      return r;
   endfunction

endpackage

// File: rtl/crc_var_step.sv
// ---------------------------------------------------------------------------
// crc_var_step
// Folds a variable number of leading bytes of one beat into the CRC state.
// One lfsr per byte count 1..DATA_WIDTH/8 runs in parallel and n_i selects
// the result; n_i = 0 passes the state through unchanged.
//   state_i  CRC register before the beat
//   data_i   beat data, byte 0 in [7:0]
//   n_i      number of leading bytes to fold (0..DATA_WIDTH/8)
//   state_o  CRC register after the beat
// ---------------------------------------------------------------------------
module crc_var_step #(
   parameter int unsigned          DATA_WIDTH = 256,
   parameter int unsigned          CRC_WIDTH  = 32,
   parameter logic [CRC_WIDTH-1:0] CRC_POLY   = 32'h04C11DB7,
   parameter bit                   REFLECT    = 1'b1
) (
   input  logic [CRC_WIDTH-1:0]              state_i,
   input  logic [DATA_WIDTH-1:0]             data_i,
   input  logic [$clog2(DATA_WIDTH/8+1)-1:0] n_i,
   output logic [CRC_WIDTH-1:0]              state_o
);

   localparam int unsigned NB = DATA_WIDTH / 8;

   logic [CRC_WIDTH-1:0] step [NB+1];

   assign step[0] = state_i;

   for (genvar k = 1; k <= NB; k++) begin : g_len
      lfsr #(
         .CRC_WIDTH (CRC_WIDTH),
         .POLY      (CRC_POLY),
         .REFLECT   (REFLECT),
         .NBYTES    (k)
      ) u_lfsr (
         .state_i (state_i),
         .data_i  (data_i[8*k-1:0]),
         .state_o (step[k])
      );
   end

   assign state_o = step[n_i];

endmodule

// File: rtl/lfsr.sv
// ---------------------------------------------------------------------------
// lfsr
// Combinational Galois CRC update over NBYTES whole bytes. The register is
// kept in normal (MSB-first) orientation; with REFLECT set, each byte is fed
// LSB first so the result matches a reflected CRC once the caller reflects
// the final state.
//   state_i  current CRC register
//   data_i   NBYTES bytes, byte 0 in [7:0] processed first
//   state_o  register after all bytes are folded in
// ---------------------------------------------------------------------------
module lfsr #(
   parameter int unsigned              CRC_WIDTH = 32,
   parameter logic [CRC_WIDTH-1:0]     POLY      = 32'h04C11DB7,
   parameter bit                       REFLECT   = 1'b1,
   parameter int unsigned              NBYTES    = 1
) (
   input  logic [CRC_WIDTH-1:0] state_i,
   input  logic [8*NBYTES-1:0]  data_i,
   output logic [CRC_WIDTH-1:0] state_o
);

   always_comb begin : p_step
      logic [CRC_WIDTH-1:0] s;
      logic                 fb;
      // NOTE: blocking assignments chain each bit step onto the previous one
      // within a single evaluation; this is pure XOR logic, not a register.
      s  = state_i;
      fb = 1'b0;
      for (int b = 0; b < int'(NBYTES); b++) begin
         for (int i = 0; i < 8; i++) begin
            fb = s[CRC_WIDTH-1] ^ (REFLECT ? data_i[8*b+i] : data_i[8*b+7-i]);
            s  = {s[CRC_WIDTH-2:0], 1'b0} ^ (fb ? POLY : '0);
         end
      end
      state_o = s;
   end

endmodule

// File: rtl/crc_stream_checker.sv
// ---------------------------------------------------------------------------
// crc_stream_checker
// Streaming CRC generator/checker. Messages arrive as valid/ready beats of
// DATA_WIDTH bits with a byte-keep mask honoured on the last beat only. The
// CRC state carries across beats; on the accepted last beat the finalised
// CRC, a compare against crc_expected_i, a keep-hole flag and the saturating
// byte count are registered and held until crc_ready_i.
//   clk_i, rst_ni                 clock, async active-low reset
//   data_i/_keep_i/_valid_i/_last_i, data_ready_o   input beat stream
//   crc_expected_i                reference CRC, sampled with the last beat
//   crc_o, crc_match_o, crc_keep_err_o, msg_bytes_o  result fields
//   crc_valid_o, crc_ready_i      result handshake
//   busy_o                        a multi-beat message is in progress
// ---------------------------------------------------------------------------
module crc_stream_checker
   import crc_pkg::*;
#(
   parameter int unsigned          DATA_WIDTH  = 256,
   parameter int unsigned          CRC_WIDTH   = 32,
   parameter logic [CRC_WIDTH-1:0] CRC_POLY    = CRC32_POLY,
   parameter logic [CRC_WIDTH-1:0] CRC_INIT    = CRC32_INIT,
   parameter logic [CRC_WIDTH-1:0] CRC_XOROUT  = CRC32_XOROUT,
   parameter bit                   REFLECT     = 1'b1,
   parameter int unsigned          COUNT_WIDTH = 16
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  logic [DATA_WIDTH-1:0]     data_i,
   input  logic [DATA_WIDTH/8-1:0]   data_keep_i,
   input  logic                      data_valid_i,
   input  logic                      data_last_i,
   output logic                      data_ready_o,
   input  logic [CRC_WIDTH-1:0]      crc_expected_i,
   output logic [CRC_WIDTH-1:0]      crc_o,
   output logic                      crc_match_o,
   output logic                      crc_keep_err_o,
   output logic [COUNT_WIDTH-1:0]    msg_bytes_o,
   output logic                      crc_valid_o,
   input  logic                      crc_ready_i,
   output logic                      busy_o
);

   localparam int unsigned NB = DATA_WIDTH / 8;
   localparam int unsigned NW = $clog2(NB + 1);

   fsm_state_e             fsm_q, fsm_d;
   logic [CRC_WIDTH-1:0]   state_q, state_d;
   logic [COUNT_WIDTH-1:0] count_q, count_d;
   logic                   valid_q, valid_d;
   logic [CRC_WIDTH-1:0]   crc_q, crc_d;
   logic                   match_q, match_d;
   logic                   keep_err_q, keep_err_d;
   logic [COUNT_WIDTH-1:0] bytes_q, bytes_d;

   logic                   accept;
   keep_info_t             keep_info;
   logic [NW-1:0]          n_sel;
   logic [CRC_WIDTH-1:0]   step_state;
   logic [CRC_WIDTH-1:0]   out_state;
   logic [CRC_WIDTH-1:0]   crc_final;
   logic [COUNT_WIDTH:0]   count_sum;
   logic [COUNT_WIDTH-1:0] count_next;

   // A held result blocks input unless the consumer takes it this cycle, so
   // a new last beat can replace the result in the same edge.
   assign data_ready_o = !valid_q || crc_ready_i;
   assign accept       = data_valid_i && data_ready_o;

   // Keep only matters on the last beat; earlier beats fold every byte.
   assign keep_info = keep_to_nbytes(MAX_KEEP_BITS'(data_keep_i), int'(NB));
   assign n_sel     = data_last_i ? NW'(keep_info.nbytes) : NW'(NB);

   crc_var_step #(
      .DATA_WIDTH (DATA_WIDTH),
      .CRC_WIDTH  (CRC_WIDTH),
      .CRC_POLY   (CRC_POLY),
      .REFLECT    (REFLECT)
   ) u_step (
      .state_i (state_q),
      .data_i  (data_i),
      .n_i     (n_sel),
      .state_o (step_state)
   );

   always_comb begin
      out_state = step_state;
      if (REFLECT) begin
         for (int i = 0; i < int'(CRC_WIDTH); i++) out_state[i] = step_state[CRC_WIDTH-1-i];
      end
      crc_final = out_state ^ CRC_XOROUT;
   end

   // Carry into the extra top bit marks overflow; the count then sticks at all-ones.
   assign count_sum  = {1'b0, count_q} + (COUNT_WIDTH+1)'(n_sel);
   assign count_next = count_sum[COUNT_WIDTH] ? '1 : count_sum[COUNT_WIDTH-1:0];

   always_comb begin
      // NOTE: every _d gets its hold value first so no path leaves it
      // unassigned; a missing default here would infer a latch.
      fsm_d      = fsm_q;
      state_d    = state_q;
      count_d    = count_q;
      valid_d    = valid_q;
      crc_d      = crc_q;
      match_d    = match_q;
      keep_err_d = keep_err_q;
      bytes_d    = bytes_q;

      if (valid_q && crc_ready_i) valid_d = 1'b0;

      if (accept) begin
         if (data_last_i) begin
            // Reload in the same edge so the next message can follow at once.
            fsm_d      = ST_IDLE;
            state_d    = CRC_INIT;
            count_d    = '0;
            valid_d    = 1'b1;
            crc_d      = crc_final;
            match_d    = (crc_final == crc_expected_i);
            keep_err_d = keep_info.err;
            bytes_d    = count_next;
         end else begin
            fsm_d   = ST_ACCUM;
            state_d = step_state;
            count_d = count_next;
         end
      end
   end

   // NOTE: registers use non-blocking assignments so all of them update from
   // the same pre-edge values.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         fsm_q      <= ST_IDLE;
         state_q    <= CRC_INIT;
         count_q    <= '0;
         valid_q    <= 1'b0;
         crc_q      <= '0;
         match_q    <= 1'b0;
         keep_err_q <= 1'b0;
         bytes_q    <= '0;
      end else begin
         fsm_q      <= fsm_d;
         state_q    <= state_d;
         count_q    <= count_d;
         valid_q    <= valid_d;
         crc_q      <= crc_d;
         match_q    <= match_d;
         keep_err_q <= keep_err_d;
         bytes_q    <= bytes_d;
      end
   end

   assign crc_o          = crc_q;
   assign crc_match_o    = match_q;
   assign crc_keep_err_o = keep_err_q;
   assign msg_bytes_o    = bytes_q;
   assign crc_valid_o    = valid_q;
   assign busy_o         = (fsm_q == ST_ACCUM);

endmodule

// File: tb/tb_crc_stream_checker.sv
// ---------------------------------------------------------------------------
// tb_crc_stream_checker
// Directed bench with two checker instances: a 32-bit beat variant and the
// default 256-bit variant. Expected CRCs are standard CRC-32 check values.
// ---------------------------------------------------------------------------
module tb_crc_stream_checker;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // 32-bit instance
   logic [31:0] d32, exp32, crc32;
   logic [3:0]  k32;
   logic        v32, l32, rdy32, m32, ke32, cv32, cr32, busy32;
   logic [15:0] nb32;

   // 256-bit instance
   logic [255:0] d256;
   logic [31:0]  k256, exp256, crc256;
   logic         v256, l256, rdy256, m256, ke256, cv256, cr256, busy256;
   logic [15:0]  nb256;

   crc_stream_checker #(.DATA_WIDTH(32)) dut32 (
      .clk_i(clk), .rst_ni(rst_n),
      .data_i(d32), .data_keep_i(k32), .data_valid_i(v32), .data_last_i(l32),
      .data_ready_o(rdy32), .crc_expected_i(exp32), .crc_o(crc32),
      .crc_match_o(m32), .crc_keep_err_o(ke32), .msg_bytes_o(nb32),
      .crc_valid_o(cv32), .crc_ready_i(cr32), .busy_o(busy32)
   );

   crc_stream_checker #(.DATA_WIDTH(256)) dut256 (
      .clk_i(clk), .rst_ni(rst_n),
      .data_i(d256), .data_keep_i(k256), .data_valid_i(v256), .data_last_i(l256),
      .data_ready_o(rdy256), .crc_expected_i(exp256), .crc_o(crc256),
      .crc_match_o(m256), .crc_keep_err_o(ke256), .msg_bytes_o(nb256),
      .crc_valid_o(cv256), .crc_ready_i(cr256), .busy_o(busy256)
   );

   int errors = 0;
   int checks = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Call at a negedge; returns at the negedge after the accepting edge.
   task automatic drive32(input logic [31:0] d, input logic [3:0] k, input logic last);
      int t;
      d32 = d; k32 = k; l32 = last; v32 = 1'b1;
      t = 0;
      #1;
      while (!rdy32) begin
         @(negedge clk); #1;
         t++;
         if (t > 50) begin
            check("drive32_ready_timeout", rdy32, 1);
            break;
         end
      end
      @(posedge clk);
      @(negedge clk);
      v32 = 1'b0; l32 = 1'b0;
   endtask

   task automatic drive256(input logic [255:0] d, input logic [31:0] k, input logic last);
      int t;
      d256 = d; k256 = k; l256 = last; v256 = 1'b1;
      t = 0;
      #1;
      while (!rdy256) begin
         @(negedge clk); #1;
         t++;
         if (t > 50) begin
            check("drive256_ready_timeout", rdy256, 1);
            break;
         end
      end
      @(posedge clk);
      @(negedge clk);
      v256 = 1'b0; l256 = 1'b0;
   endtask

   task automatic send_123456789_32(input logic [31:0] expected);
      exp32 = expected;
      drive32(32'h34333231, 4'hF, 1'b0);
      drive32(32'h38373635, 4'hF, 1'b0);
      check("busy_mid_msg32", busy32, 1);
      drive32(32'h00000039, 4'b0001, 1'b1);
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog: time limit reached");
      $fatal(1);
   end

   initial begin
      int c1, c2;
      logic [255:0] w;
      rst_n = 1'b0;
      d32 = '0; k32 = '0; v32 = 1'b0; l32 = 1'b0; exp32 = '0; cr32 = 1'b1;
      d256 = '0; k256 = '0; v256 = 1'b0; l256 = 1'b0; exp256 = '0; cr256 = 1'b1;
      repeat (3) @(negedge clk);

      // Reset state
      check("rst_valid", cv32, 0);
      check("rst_crc", crc32, 0);
      check("rst_bytes", nb32, 0);
      check("rst_busy", busy32, 0);
      check("rst_ready", rdy32, 1);
      check("rst_valid256", cv256, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // "123456789" over three 32-bit beats
      send_123456789_32(32'hCBF43926);
      check("msg9_valid", cv32, 1);
      check("msg9_crc", crc32, 32'hCBF43926);
      check("msg9_match", m32, 1);
      check("msg9_bytes", nb32, 9);
      check("msg9_keep_err", ke32, 0);
      check("msg9_busy", busy32, 0);

      // Same message, wrong expected value
      send_123456789_32(32'hCBF43927);
      check("msg9_bad_crc", crc32, 32'hCBF43926);
      check("msg9_bad_match", m32, 0);

      // Single byte "a"
      exp32 = 32'hE8B7BE43;
      drive32(32'h00000061, 4'b0001, 1'b1);
      check("a_crc", crc32, 32'hE8B7BE43);
      check("a_bytes", nb32, 1);
      check("a_match", m32, 1);

      // Empty message: keep all zero
      drive32(32'h12345678, 4'b0000, 1'b1);
      check("empty_crc", crc32, 32'h00000000);
      check("empty_bytes", nb32, 0);
      check("empty_keep_err", ke32, 0);

      // Hole in keep: only byte 0 counts, flag raised
      drive32(32'h00FF0061, 4'b0101, 1'b1);
      check("hole_crc", crc32, 32'hE8B7BE43);
      check("hole_bytes", nb32, 1);
      check("hole_keep_err", ke32, 1);

      // Consumer ready with no new beat: valid clears, fields hold
      @(negedge clk);
      check("accepted_valid", cv32, 0);
      check("accepted_crc_hold", crc32, 32'hE8B7BE43);

      // Backpressure: result held, next beat waits
      cr32 = 1'b0;
      exp32 = 32'hE8B7BE43;
      drive32(32'h00000061, 4'b0001, 1'b1);
      check("bp_valid", cv32, 1);
      d32 = 32'h34333231; k32 = 4'hF; l32 = 1'b0; v32 = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("bp_ready_low", rdy32, 0);
         check("bp_crc_stable", crc32, 32'hE8B7BE43);
         check("bp_valid_held", cv32, 1);
         check("bp_no_accept", busy32, 0);
      end
      cr32 = 1'b1;
      #1;
      check("bp_release_ready", rdy32, 1);
      @(posedge clk);
      @(negedge clk);
      v32 = 1'b0;
      check("bp_release_valid", cv32, 0);
      check("bp_first_beat_taken", busy32, 1);
      exp32 = 32'hCBF43926;
      drive32(32'h38373635, 4'hF, 1'b0);
      drive32(32'h00000039, 4'b0001, 1'b1);
      check("bp_msg_crc", crc32, 32'hCBF43926);
      check("bp_msg_bytes", nb32, 9);
      check("bp_msg_match", m32, 1);

      // 256-bit: 32 zero bytes, twice back to back
      exp256 = 32'h190A55AD;
      drive256('0, 32'hFFFFFFFF, 1'b1);
      c1 = cyc;
      check("z32_valid", cv256, 1);
      check("z32_crc", crc256, 32'h190A55AD);
      check("z32_bytes", nb256, 32);
      check("z32_match", m256, 1);
      drive256('0, 32'hFFFFFFFF, 1'b1);
      c2 = cyc;
      check("z32_b2b_valid", cv256, 1);
      check("z32_b2b_crc", crc256, 32'h190A55AD);
      check("z32_b2b_spacing", c2 - c1, 1);

      // 256-bit: "123456789" in one beat, junk above the keep mask
      w = '1;
      w[71:0] = 72'h393837363534333231;
      exp256 = 32'hCBF43926;
      drive256(w, 32'h000001FF, 1'b1);
      check("w9_crc", crc256, 32'hCBF43926);
      check("w9_bytes", nb256, 9);
      check("w9_keep_err", ke256, 0);
      check("w9_match", m256, 1);

      // 256-bit: byte count saturates (2050 full beats = 65600 bytes)
      for (int i = 0; i < 2050; i++) drive256('0, '0, 1'b0);
      check("sat_busy", busy256, 1);
      drive256('0, 32'h00000000, 1'b1);
      check("sat_bytes", nb256, 16'hFFFF);
      check("sat_valid", cv256, 1);

      // Reset in the middle of a message on the 32-bit instance
      drive32(32'h34333231, 4'hF, 1'b0);
      drive32(32'h38373635, 4'hF, 1'b0);
      check("pre_rst_busy", busy32, 1);
      rst_n = 1'b0;
      #1;
      check("mid_rst_busy", busy32, 0);
      check("mid_rst_valid", cv32, 0);
      check("mid_rst_crc", crc32, 0);
      check("mid_rst_bytes", nb32, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      send_123456789_32(32'hCBF43926);
      check("post_rst_crc", crc32, 32'hCBF43926);
      check("post_rst_bytes", nb32, 9);
      check("post_rst_match", m32, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/crc_stream_checker.md
Name: crc_stream_checker

Overview:
Parametrised streaming CRC generator/checker, the successor to the fixed 256-bit, 8-beat batch checker. It accepts messages of any length as a valid/ready stream of DATA_WIDTH-bit beats, with a byte-keep mask on the last beat, and carries the CRC state across beats. On the last beat it outputs the finalised CRC, a compare result against an expected value, and the message byte count. The result is held until the consumer accepts it, and input backpressure follows from that hold. It sits between the packet receive path and the frame-status logic, targeting 200 MHz on the Artix-7.

Parameters:
DATA_WIDTH, 256, beat width in bits; multiple of 8, range 8..512.
CRC_WIDTH, 32, CRC register width.
CRC_POLY, 32'h04C11DB7, generator polynomial (normal form).
CRC_INIT, 32'hFFFFFFFF, state loaded at the start of each message.
CRC_XOROUT, 32'hFFFFFFFF, XOR applied to the final state.
REFLECT, 1, 1 = bit-reflected input and output (LSB of each byte first).
COUNT_WIDTH, 16, width of the message byte counter.

Ports:
clk_i  in  1  single clock.
rst_ni  in  1  reset, asynchronous assert, active-low.
data_i  in  DATA_WIDTH  beat data; byte 0 = data_i[7:0] is the first byte on the wire.
data_keep_i  in  DATA_WIDTH/8  byte enables; sampled only on the last beat.
data_valid_i  in  1  beat valid.
data_last_i  in  1  final beat of the message.
data_ready_o  out  1  beat accepted when data_valid_i && data_ready_o.
crc_expected_i  in  CRC_WIDTH  expected CRC, sampled on the accepted last beat.
crc_o  out  CRC_WIDTH  finalised CRC.
crc_match_o  out  1  crc_o == sampled expected value.
crc_keep_err_o  out  1  last-beat keep mask was non-contiguous.
msg_bytes_o  out  COUNT_WIDTH  bytes consumed in the message, saturating.
crc_valid_o  out  1  result valid; held until crc_ready_i.
crc_ready_i  in  1  consumer accepts the result.
busy_o  out  1  a message is in progress (at least one non-last beat accepted).

Behaviour:
- Reset (async, rst_ni low):
  - state = CRC_INIT, byte count = 0, busy_o = 0.
  - crc_valid_o = 0, crc_o = 0, crc_match_o = 0, crc_keep_err_o = 0, msg_bytes_o = 0.
  - Reset mid-message discards the partial message and any unaccepted result.
- data_ready_o = !crc_valid_o || crc_ready_i (combinational).
- FSM states: IDLE (state = INIT, count = 0) -> ACCUM on an accepted non-last beat.
  - ACCUM stays on further non-last beats; returns to IDLE on the accepted last beat.
  - A last beat accepted in IDLE (single-beat message) stays in IDLE.
- Non-last beat:
  - keep is ignored and all DATA_WIDTH/8 bytes are folded into the state.
  - count += DATA_WIDTH/8, saturating at all-ones.
- Last beat, byte count n:
  - n = number of contiguous ones in data_keep_i starting at bit 0; only bytes 0..n-1 are folded.
  - crc_keep_err_o = 1 if any keep bit above the first zero is set.
  - n = 0 is legal: no bytes are folded and the accumulated state is finalised.
  - An empty message yields CRC_INIT ^ CRC_XOROUT.
- Latency: last beat accepted at edge N -> crc_valid_o, crc_o, crc_match_o, crc_keep_err_o and msg_bytes_o update at edge N (visible cycle N+1).
  - State and count reload to INIT/0 in the same edge, so the next message may start the following cycle with no bubble.
- Output hold:
  - While crc_valid_o && !crc_ready_i, all result outputs are stable and data_ready_o = 0.
  - With crc_ready_i = 1, a new last beat replaces the result in the same edge (crc_valid_o stays 1).
  - Otherwise an accepted result clears crc_valid_o; crc_o and the other result fields hold their last value.
- Data arithmetic: per-byte-count next-state is pure XOR (Galois LFSR, REFLECT per parameter).
  - The n-byte result is selected by a mux on n.
  - crc_o = (REFLECT ? reflected state : state) ^ CRC_XOROUT.

Decomposition:
- crc_pkg:
  - CRC-32 constants (POLY, INIT, XOROUT, residue 32'hC704DD7B).
  - Function keep_to_nbytes (contiguous count + error flag).
  - Function reflect32.
  - FSM state enum {IDLE, ACCUM}.
- Sub-module crc_var_step: combinational; inputs state_in, data_in and n, output next state.
  - Internally it instantiates the existing lfsr module once per byte count 1..DATA_WIDTH/8 (DATA_WIDTH = 8*k) and muxes on n (n = 0 passes state through).

Test Plan:
- DATA_WIDTH=32, beats 0x34333231, 0x38373635, 0x00000039 keep 4'b0001 last, expected 0xCBF43926 -> crc_o=0xCBF43926, crc_match_o=1, msg_bytes_o=9, crc_valid_o one cycle after the last beat.
- Same message with expected 0xCBF43927 -> crc_match_o=0. Single beat 0x00000061 keep 4'b0001 -> crc_o=0xE8B7BE43, msg_bytes_o=1.
- Empty message: last beat with keep 0 in IDLE -> crc_o=0x00000000, msg_bytes_o=0. Keep 4'b0101 -> crc_keep_err_o=1, n=1.
- DATA_WIDTH=256, one beat of 32 zero bytes, keep all ones -> crc_o=0x190A55AD. Two back-to-back such messages -> two results in consecutive cycles when crc_ready_i=1.
- Backpressure: crc_ready_i=0 for 5 cycles after a result -> crc_o stable, data_ready_o=0, no beat lost. Release -> the next message result is correct.
- rst_ni pulsed low mid-message (after 2 beats) -> busy_o=0, crc_valid_o=0 immediately. The following "123456789" message -> 0xCBF43926.
